sub_64bit_seq: RTL

SUB_64BIT_SEQ -- requirements
Module: sub_64bit_seq

---
 rtl/sub64_pkg.sv | 21 ++
 rtl/sub_chunk.sv | 15 +
 rtl/sub_64bit_seq.sv | 107 ++++++++++
 3 files changed

// File: rtl/sub64_pkg.sv
// rtl/sub64_pkg.sv - shared types and sizing for the chunked 64-bit subtractor
package sub64_pkg;

  localparam int WIDTH_DEF   = 64;
  localparam int CHUNK_W_DEF = 16;
  localparam int NCHUNK_DEF  = WIDTH_DEF / CHUNK_W_DEF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  function automatic int nchunk(input int width, input int chunk_w);
    return width / chunk_w;
  endfunction

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sub_chunk.sv
// rtl/sub_chunk.sv - combinational CHUNK_W-bit subtractor slice with borrow in/out
module sub_chunk #(
  parameter int CHUNK_W = 16
) (
  input  logic [CHUNK_W-1:0] a,
  input  logic [CHUNK_W-1:0] b,
  input  logic               bin,
  output logic [CHUNK_W-1:0] d,
  output logic               bout
);

  // One extra bit catches the borrow as the sign of the widened difference.
  assign {bout, d} = {1'b0, a} - {1'b0, b} - {{CHUNK_W{1'b0}}, bin};

endmodule

// File: rtl/sub_64bit_seq.sv
// rtl/sub_64bit_seq.sv - multi-cycle A - B - Bin, one CHUNK_W slice per clock
// The final slice is retired in IDLE so a held start keeps NCHUNK-cycle throughput.
module sub_64bit_seq
  import sub64_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int CHUNK_W = CHUNK_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Zero,
  output logic             Ovf
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK_W);
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam int ACC_W  = WIDTH - CHUNK_W;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               borrow_q;
  logic               fin;
  logic [ACC_W-1:0]   acc;

  logic [CHUNK_W-1:0] a_sl [NCHUNK];
  logic [CHUNK_W-1:0] b_sl [NCHUNK];
  logic [CHUNK_W-1:0] d;
  logic               bout;
  logic [WIDTH-1:0]   result;

  for (genvar i = 0; i < NCHUNK; i++) begin : g_slice
    assign a_sl[i] = a_q[i*CHUNK_W +: CHUNK_W];
    assign b_sl[i] = b_q[i*CHUNK_W +: CHUNK_W];
  end

  sub_chunk #(.CHUNK_W(CHUNK_W)) u_chunk (
    .a    (a_sl[cnt]),
    .b    (b_sl[cnt]),
    .bin  (borrow_q),
    .d    (d),
    .bout (bout)
  );

  // Completed slices shift in from the top so slice 0 ends at the bottom.
  assign result = {d, acc};
  assign ready  = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      fin      <= 1'b0;
      acc      <= '0;
      done     <= 1'b0;
      Diff     <= '0;
      Borrow   <= 1'b0;
      Zero     <= 1'b0;
      Ovf      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // Retire the top slice from the still-latched operands before any new accept lands.
          if (fin) begin
            fin    <= 1'b0;
            done   <= 1'b1;
            Diff   <= result;
            Borrow <= bout;
            Zero   <= (result == '0);
            Ovf    <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d[CHUNK_W-1] != a_q[WIDTH-1]);
          end
          if (start) begin
            a_q      <= A;
            b_q      <= B;
            borrow_q <= Bin;
            cnt      <= '0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc      <= ACC_W'({d, acc} >> CHUNK_W);
          borrow_q <= bout;
          cnt      <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(NCHUNK - 2)) begin
            fin   <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
